serial_imem_loader: RTL

SERIAL_IMEM_LOADER -- requirements
Module: serial_imem_loader

---
 rtl/serial_imem_loader.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/serial_imem_loader.sv
// serial_imem_loader: UART 8N1 boot loader that fills instruction SRAM.
// Optional trailing XOR checksum byte enabled by `define LOADER_CHECKSUM_EN.
module serial_imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_WORDS    = 1024
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        RXD,
  output logic        MEM_CSN,
  output logic        MEM_WEN,
  output logic [11:0] MEM_ADDR,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_DO,
  output logic        CPU_RSTn,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]   N_MAX    = 16'(MAX_WORDS);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_BITS, RX_STOP
  } rx_t;

  typedef enum logic [2:0] {
    S_CNT0, S_CNT1, S_DATA, S_WRITE, S_DONE, S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  logic rxd_q1, rxd_q2, rxd_d;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rxd_q1 <= 1'b1;
      rxd_q2 <= 1'b1;
      rxd_d  <= 1'b1;
    end else begin
      rxd_q1 <= RXD;
      rxd_q2 <= rxd_q1;
      rxd_d  <= rxd_q2;
    end
  end

  rx_t           rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_vld;
  logic          rx_ferr;

  // rx_sh stays stable while rx_vld is high, so it doubles as the byte
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rx_st   <= RX_IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      rx_vld <= 1'b0;
      unique case (rx_st)
        RX_IDLE: begin
          if (rxd_d && !rxd_q2) begin
            rx_st  <= RX_START;
            rx_cnt <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rxd_q2 ? RX_IDLE : RX_BITS;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_BITS: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_sh  <= {rxd_q2, rx_sh[7:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt  <= '0;
            rx_vld  <= 1'b1;
            rx_ferr <= !rxd_q2;
            rx_st   <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  state_t      state;
  logic [7:0]  n_lo;
  logic [15:0] n_words;
  logic [15:0] n_rx;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign n_rx = {rx_sh, n_lo};

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= S_CNT0;
      n_lo     <= '0;
      n_words  <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word_buf <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
      MEM_CSN  <= 1'b1;
      MEM_WEN  <= 1'b1;
      MEM_ADDR <= '0;
      MEM_BE   <= '0;
      MEM_DO   <= '0;
      CPU_RSTn <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      unique case (state)
        S_CNT0: begin
          if (rx_vld && !rx_ferr) begin
            n_lo  <= rx_sh;
            BUSY  <= 1'b1;
            state <= S_CNT1;
          end
        end
        S_CNT1: begin
          if (rx_vld) begin
            n_words <= n_rx;
            if (rx_ferr || n_rx > N_MAX) state <= S_ERR;
            else if (n_rx == 16'd0)      state <= S_TAIL;
            else                         state <= S_DATA;
          end
        end
        S_DATA: begin
          if (rx_vld) begin
            if (rx_ferr) begin
              state <= S_ERR;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              word_buf <= {rx_sh, word_buf[23:8]};
`ifdef LOADER_CHECKSUM_EN
              csum     <= csum ^ rx_sh;
`endif
              if (byte_idx == 2'd3) begin
                MEM_DO   <= {rx_sh, word_buf};
                MEM_ADDR <= {2'b00, word_idx[9:0]};
                MEM_BE   <= 4'b1111;
                MEM_CSN  <= 1'b0;
                MEM_WEN  <= 1'b0;
                state    <= S_WRITE;
              end
            end
          end
        end
        S_WRITE: begin
          MEM_CSN  <= 1'b1;
          MEM_WEN  <= 1'b1;
          word_idx <= word_idx + 16'd1;
          if (word_idx == n_words - 16'd1) state <= S_TAIL;
          else                             state <= S_DATA;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (rx_vld) begin
            if (rx_ferr || rx_sh != csum) state <= S_ERR;
            else                          state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          BUSY     <= 1'b0;
          DONE     <= 1'b1;
          CPU_RSTn <= 1'b1;
        end
        S_ERR: begin
          BUSY     <= 1'b0;
          ERR      <= 1'b1;
          CPU_RSTn <= 1'b0;
        end
        default: state <= S_ERR;
      endcase
    end
  end

endmodule
